// File: rtl/frame_capture_if.sv
// Video input and buffer-write bus for the frame capture block.
interface frame_capture_if;
  logic        start;
  logic        vid_vsync;
  logic        vid_de;
  logic [7:0]  vid_r;
  logic [7:0]  vid_g;
  logic [7:0]  vid_b;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;
  logic        frame_error;

  modport master (
    output start, vid_vsync, vid_de,
    output vid_r, vid_g, vid_b,
    input  wr_en, wr_addr, wr_data,
    input  busy, done, frame_error
  );

  modport slave (
    input  start, vid_vsync, vid_de,
    input  vid_r, vid_g, vid_b,
    output wr_en, wr_addr, wr_data,
    output busy, done, frame_error
  );
endinterface

// File: rtl/frame_capture.sv
// Captures one windowed frame of DE/VSYNC video into a
// row-major input buffer, one write per in-window pixel.
module frame_capture #(
  parameter int IMAGE_WIDTH  = 224,
  parameter int IMAGE_HEIGHT = 224,
  parameter int H_OFFSET     = 208,
  parameter int V_OFFSET     = 128
) (
  input logic            clk,
  input logic            rst,
  frame_capture_if.slave bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] CAPTURE    = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  localparam logic [10:0] XLO  = 11'(H_OFFSET);
  localparam logic [10:0] XHI  = 11'(H_OFFSET + IMAGE_WIDTH);
  localparam logic [9:0]  YLO  = 10'(V_OFFSET);
  localparam logic [9:0]  YHI  = 10'(V_OFFSET + IMAGE_HEIGHT);
  localparam logic [15:0] LAST = 16'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  logic [1:0]  state_q, state_d;
  logic        vsync_q, de_q;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic [15:0] addr_cnt_q, addr_cnt_d;
  logic        err_q, err_d;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [23:0] wr_data_q;
  logic        busy_q, done_q;

  logic frame_start, de_fall;
  logic in_win, last_px, do_wr;

  assign frame_start = vsync_q & ~bus.vid_vsync;
  assign de_fall     = de_q & ~bus.vid_de;

  assign in_win = (state_q == CAPTURE) && bus.vid_de
               && (x_cnt_q >= XLO) && (x_cnt_q < XHI)
               && (y_cnt_q >= YLO) && (y_cnt_q < YHI);

  assign last_px = in_win && (addr_cnt_q == LAST);
  // a final pixel coinciding with a new frame still completes
  assign do_wr   = in_win && (last_px || !frame_start);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WAIT_FRAME;
          err_d   = 1'b0;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (last_px) begin
          state_d = DONE;
        end else if (frame_start) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    addr_cnt_d = addr_cnt_q;
    if (state_q == WAIT_FRAME && frame_start) begin
      x_cnt_d    = '0;
      y_cnt_d    = '0;
      addr_cnt_d = '0;
    end else if (state_q == CAPTURE) begin
      if (de_fall) begin
        x_cnt_d = '0;
        y_cnt_d = y_cnt_q + 10'd1;
      end else if (bus.vid_de) begin
        x_cnt_d = x_cnt_q + 11'd1;
      end
      if (do_wr) addr_cnt_d = addr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b1;
      de_q       <= 1'b0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      addr_cnt_q <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= bus.vid_vsync;
      de_q       <= bus.vid_de;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      err_q      <= err_d;
      wr_en_q    <= do_wr;
      if (do_wr) begin
        wr_addr_q <= addr_cnt_q;
        wr_data_q <= {bus.vid_r, bus.vid_g, bus.vid_b};
      end
      busy_q <= (state_d == WAIT_FRAME) || (state_d == CAPTURE);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frame_error = err_q;

endmodule
